// File: rtl/msf_pkg.sv
// Shared constants and helpers for the MSF local timebase.
// Defaults describe the production clock; modules derive their own from parameters.
package msf_pkg;

  localparam int CLK_FREQ_DEF = 12500;
  localparam int TICKS_DEF    = 10;
  localparam int TRIM_W_DEF   = 4;

  localparam int TICK_LEN   = CLK_FREQ_DEF / TICKS_DEF;
  localparam int TICK_IDX_W = $clog2(TICKS_DEF);
  localparam int OFFSET_W   = $clog2(CLK_FREQ_DEF) + 1;

  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Fold a position in the second into a signed phase error around zero.
  function automatic int f_wrap_offset(input int pos, input int clk_freq);
    return (pos < clk_freq / 2) ? pos : pos - clk_freq;
  endfunction

endpackage

// File: rtl/msf_timebase_tick_divider.sv
// Per-tick cycle counter with a loadable length and a synchronous clear.
// last_o is the raw end-of-tick decode; the caller gates it with enable.
module tick_divider #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] cyc_o,
  output logic             last_o
);

  logic [LEN_W-1:0] cyc_q, cyc_d;

  assign last_o = (cyc_q == len_i - 1'b1);
  assign cyc_o  = cyc_q;

  always_comb begin
    cyc_d = cyc_q;
    if (clr_i) begin
      cyc_d = '0;
    end else if (en_i) begin
      cyc_d = last_o ? '0 : cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/msf_timebase.sv
// MSF local timebase: ticks, seconds, per-second trim and re-phase.
// Reports signed phase error of the local second at each sync.
module msf_timebase
  import msf_pkg::*;
#(
  parameter int CLK_FREQ      = 12500,
  parameter int TICKS_PER_SEC = 10,
  parameter int TRIM_W        = 4,
  localparam int IDX_W        = f_idx_w(TICKS_PER_SEC),
  localparam int OFF_W        = $clog2(CLK_FREQ) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     sync_i,
  input  logic signed [TRIM_W-1:0] trim_i,
  output logic                     tick_o,
  output logic                     second_o,
  output logic [IDX_W-1:0]         tick_idx_o,
  output logic signed [OFF_W-1:0]  offset_o,
  output logic                     offset_valid_o
);

  localparam int TLEN  = CLK_FREQ / TICKS_PER_SEC;
  localparam int LEN_W = $clog2(TLEN) + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TICKS_PER_SEC - 1);
  localparam logic [LEN_W-1:0] TLEN_V   = LEN_W'(TLEN);

  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [OFF_W-1:0]         pos_q, pos_d;
  logic signed [OFF_W-1:0]  off_q, off_d;
  logic                     ov_q, ov_d;
  logic signed [TRIM_W-1:0] trim_q, trim_d;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cyc;
  logic             last;
  logic             is_last_idx;
  logic             tick;

  assign is_last_idx = (idx_q == IDX_LAST);

  // Only the final tick of the second absorbs the trim.
  assign len = is_last_idx ? TLEN_V + LEN_W'(trim_q) : TLEN_V;

  tick_divider #(
    .LEN_W (LEN_W)
  ) u_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (enable_i),
    .clr_i  (sync_i),
    .len_i  (len),
    .cyc_o  (cyc),
    .last_o (last)
  );

  assign tick     = enable_i & last;
  assign tick_o   = tick;
  assign second_o = tick & is_last_idx;

  assign tick_idx_o     = idx_q;
  assign offset_o       = off_q;
  assign offset_valid_o = ov_q;

  always_comb begin
    idx_d  = idx_q;
    pos_d  = pos_q;
    off_d  = off_q;
    ov_d   = 1'b0;
    trim_d = trim_q;
    if (sync_i) begin
      idx_d = '0;
      pos_d = '0;
      off_d = $signed(OFF_W'(f_wrap_offset(int'(pos_q), CLK_FREQ)));
      ov_d  = 1'b1;
      if (TICKS_PER_SEC == 1) trim_d = trim_i;
    end else if (enable_i) begin
      pos_d = pos_q + 1'b1;
      if (last) begin
        idx_d = is_last_idx ? '0 : idx_q + 1'b1;
        if (is_last_idx) pos_d = '0;
        // Latch trim as the last tick begins so it is stable for that tick.
        if (idx_d == IDX_LAST) trim_d = trim_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      pos_q  <= '0;
      off_q  <= '0;
      ov_q   <= 1'b0;
      trim_q <= '0;
    end else begin
      idx_q  <= idx_d;
      pos_q  <= pos_d;
      off_q  <= off_d;
      ov_q   <= ov_d;
      trim_q <= trim_d;
    end
  end

  logic unused_cyc;
  assign unused_cyc = ^cyc;

endmodule

// File: tb/tb_msf_timebase.sv
// Directed bench for msf_timebase at CLK_FREQ=20, TICKS_PER_SEC=4, TRIM_W=2.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_msf_timebase;

  localparam int CF  = 20;
  localparam int TPS = 4;
  localparam int TW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 enable_i = 1'b0;
  logic                 sync_i = 1'b0;
  logic signed [TW-1:0] trim_i = '0;
  logic                 tick_o;
  logic                 second_o;
  logic [1:0]           tick_idx_o;
  logic signed [5:0]    offset_o;
  logic                 offset_valid_o;

  int   n_run = 0;
  int   n_fail = 0;
  logic s_tick, s_sec, s_ov;
  int   s_idx, s_off;

  always #5 clk = ~clk;

  msf_timebase #(
    .CLK_FREQ      (CF),
    .TICKS_PER_SEC (TPS),
    .TRIM_W        (TW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .sync_i         (sync_i),
    .trim_i         (trim_i),
    .tick_o         (tick_o),
    .second_o       (second_o),
    .tick_idx_o     (tick_idx_o),
    .offset_o       (offset_o),
    .offset_valid_o (offset_valid_o)
  );

  typedef struct {
    int trim;
    int sec[3];
  } trim_vec_t;

  typedef struct {
    int   pre;
    logic en;
    int   off;
    logic sec;
  } sync_vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic sample();
    s_tick = tick_o;
    s_sec  = second_o;
    s_idx  = int'(tick_idx_o);
    s_off  = int'(offset_o);
    s_ov   = offset_valid_o;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int tr);
    rst_ni   = 1'b0;
    enable_i = 1'b1;
    sync_i   = 1'b0;
    trim_i   = TW'(tr);
    @(posedge clk); #1;
    @(negedge clk);
    sample();
    chk("rst_tick", int'(s_tick), 0);
    chk("rst_sec", int'(s_sec), 0);
    chk("rst_idx", s_idx, 0);
    chk("rst_off", s_off, 0);
    chk("rst_ov", int'(s_ov), 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic run_nominal(input string tag);
    for (int c = 0; c <= 20; c++) begin
      step();
      chk({tag, "_tick"}, int'(s_tick), (c % 5 == 4) ? 1 : 0);
      chk({tag, "_sec"}, int'(s_sec), (c == 19) ? 1 : 0);
      chk({tag, "_idx"}, s_idx, (c / 5) % 4);
    end
  endtask

  trim_vec_t tv[3];
  sync_vec_t sv[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{trim: 1,  sec: '{20, 41, 62}};
    tv[1] = '{trim: -1, sec: '{18, 37, 56}};
    tv[2] = '{trim: 0,  sec: '{19, 39, 59}};

    sv[0] = '{pre: 7,  en: 1'b1, off: 7,   sec: 1'b0};
    sv[1] = '{pre: 15, en: 1'b1, off: -5,  sec: 1'b0};
    sv[2] = '{pre: 19, en: 1'b1, off: -1,  sec: 1'b1};
    sv[3] = '{pre: 10, en: 1'b1, off: -10, sec: 1'b0};
    sv[4] = '{pre: 9,  en: 1'b1, off: 9,   sec: 1'b0};
    sv[5] = '{pre: 3,  en: 1'b0, off: 3,   sec: 1'b0};
    sv[6] = '{pre: 0,  en: 1'b1, off: 0,   sec: 1'b0};

    // Nominal run from reset.
    do_reset(0);
    run_nominal("nom");

    // Held trim values.
    foreach (tv[i]) begin
      int got[3];
      int seen;
      got  = '{-1, -1, -1};
      seen = 0;
      do_reset(tv[i].trim);
      for (int c = 0; c < 70; c++) begin
        step();
        if (s_sec && seen < 3) begin
          got[seen] = c;
          seen++;
        end
      end
      for (int k = 0; k < 3; k++) chk($sformatf("trim%0d_sec%0d", tv[i].trim, k), got[k], tv[i].sec[k]);
    end

    // Sync capture table.
    foreach (sv[i]) begin
      string nm;
      nm = $sformatf("sync_p%0d", sv[i].pre);
      do_reset(0);
      repeat (sv[i].pre) step();
      enable_i = sv[i].en;
      sync_i   = 1'b1;
      step();
      chk({nm, "_secpulse"}, int'(s_sec), int'(sv[i].sec));
      sync_i   = 1'b0;
      enable_i = 1'b1;
      step();
      chk({nm, "_off"}, s_off, sv[i].off);
      chk({nm, "_ov"}, int'(s_ov), 1);
      chk({nm, "_idx"}, s_idx, 0);
      step();
      chk({nm, "_ov_clr"}, int'(s_ov), 0);
      step();
      step();
      chk({nm, "_tick_early"}, int'(s_tick), 0);
      step();
      chk({nm, "_tick"}, int'(s_tick), 1);
    end

    // Back-to-back syncs.
    do_reset(0);
    repeat (5) step();
    sync_i = 1'b1;
    step();
    step();
    chk("b2b_off1", s_off, 5);
    chk("b2b_ov1", int'(s_ov), 1);
    sync_i = 1'b0;
    step();
    chk("b2b_off2", s_off, 0);
    chk("b2b_ov2", int'(s_ov), 1);

    // Enable low for 6 cycles at pos=3.
    begin
      int got;
      got = -1;
      do_reset(0);
      repeat (3) step();
      enable_i = 1'b0;
      for (int c = 3; c < 9; c++) begin
        step();
        chk("dis_tick", int'(s_tick), 0);
        chk("dis_sec", int'(s_sec), 0);
        chk("dis_idx", s_idx, 0);
      end
      enable_i = 1'b1;
      for (int c = 9; c < 40; c++) begin
        step();
        if (s_sec) begin
          got = c;
          break;
        end
      end
      chk("dis_sec_delay", got, 25);
    end

    // Trim raised after the last tick has started.
    begin
      int got[2];
      int seen;
      got  = '{-1, -1};
      seen = 0;
      do_reset(0);
      for (int c = 0; c < 45; c++) begin
        if (c == 15) trim_i = 2'sd1;
        step();
        if (s_sec && seen < 2) begin
          got[seen] = c;
          seen++;
        end
      end
      chk("late_trim_sec0", got[0], 19);
      chk("late_trim_sec1", got[1], 40);
    end

    // Asynchronous reset mid-tick at pos=12.
    do_reset(0);
    repeat (12) step();
    rst_ni = 1'b0;
    #1;
    chk("mrst_idx_now", int'(tick_idx_o), 0);
    chk("mrst_tick_now", int'(tick_o), 0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("mrst_tick", int'(s_tick), 0);
      chk("mrst_sec", int'(s_sec), 0);
    end
    rst_ni = 1'b1;
    run_nominal("mrst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
